// File: rtl/modbus_rtu_pkg.sv
// Shared types, constants and helpers for the Modbus RTU sequencer and CRC engine.
package modbus_rtu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCrc,
    StGap,
    StSend,
    StWaitTx,
    StWaitRsp,
    StDone
  } state_e;

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'hA001;
  localparam int unsigned FRAME_BYTES = 8;

  // One bit of reflected CRC16/Modbus; data bits enter LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[0] ^ din;
    return fb ? ((crc >> 1) ^ CRC_POLY) : (crc >> 1);
  endfunction

  // Wire order of the 8 frame bytes; the CRC goes low byte first.
  function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                            input logic [7:0]  addr,
                                            input logic [7:0]  func,
                                            input logic [15:0] w0,
                                            input logic [15:0] w1,
                                            input logic [15:0] crc);
    logic [7:0] b;
    case (idx)
      3'd0:    b = addr;
      3'd1:    b = func;
      3'd2:    b = w0[15:8];
      3'd3:    b = w0[7:0];
      3'd4:    b = w1[15:8];
      3'd5:    b = w1[7:0];
      3'd6:    b = crc[7:0];
      default: b = crc[15:8];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/modbus_crc16_serial.sv
// Bit-serial CRC16/Modbus engine: a byte load consumes bit 0 immediately and the
// remaining 7 bits on the following 7 clocks, so each byte costs exactly 8 clocks.
module modbus_crc16_serial
  import modbus_rtu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;
  logic [6:0]  sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;

  // Next-state: clear has priority, then a new byte, then drain the shift register.
  always_comb begin
    crc_d = crc_q;
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      crc_d = CRC_INIT;
      sh_d  = '0;
      cnt_d = '0;
    end else if (load_i) begin
      crc_d = crc_step(crc_q, byte_i[0]);
      sh_d  = byte_i[7:1];
      cnt_d = 3'd7;
    end else if (cnt_q != 3'd0) begin
      crc_d = crc_step(crc_q, sh_q[0]);
      sh_d  = {1'b0, sh_q[6:1]};
      cnt_d = cnt_q - 3'd1;
    end
  end

  // CRC state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= CRC_INIT;
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      crc_q <= crc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/modbus_rtu_master_sequencer.sv
// Modbus RTU master request sequencer: latch request, CRC it, wait the idle gap,
// send 8 bytes over the byte UART handshake, then await the response with retries.
module modbus_rtu_master_sequencer
  import modbus_rtu_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned GAP_CLKS    = CLK_FREQ / BAUD_RATE * 11 * 35 / 10,
  parameter int unsigned RSP_TIMEOUT = 500000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_dev_addr,
  input  logic [7:0]  req_func,
  input  logic [15:0] req_word0,
  input  logic [15:0] req_word1,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  input  logic        rsp_done,
  output logic        busy,
  output logic [15:0] frame_crc,
  output logic        done,
  output logic        timeout
);

  localparam int unsigned GapW = $clog2(GAP_CLKS);
  localparam int unsigned RspW = $clog2(RSP_TIMEOUT);
  localparam logic [GapW-1:0] GapLast   = GapW'(GAP_CLKS - 1);
  localparam logic [RspW-1:0] RspLast   = RspW'(RSP_TIMEOUT - 1);
  localparam logic [2:0]      LastIdx   = 3'(FRAME_BYTES - 1);
  localparam logic [2:0]      MaxRetry  = 3'(MAX_RETRY);
  localparam logic [5:0]      CrcLast   = 6'd47;

  state_e          state_q, state_d;
  logic [5:0]      crc_cnt_q, crc_cnt_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [RspW-1:0] rsp_cnt_q, rsp_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      retry_q, retry_d;
  logic [7:0]      addr_q, func_q;
  logic [15:0]     w0_q, w1_q;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;
  logic            latch;
  logic            crc_clr, crc_load;
  logic [7:0]      crc_byte;
  logic [15:0]     crc;

  modbus_crc16_serial u_crc (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (crc_clr),
    .load_i (crc_load),
    .byte_i (crc_byte),
    .crc_o  (crc)
  );

  // Next-state, counters and registered-output decisions.
  always_comb begin
    state_d    = state_q;
    crc_cnt_d  = crc_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    idx_d      = idx_q;
    retry_d    = retry_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    latch      = 1'b0;
    crc_clr    = 1'b0;
    crc_load   = 1'b0;
    crc_byte   = frame_byte(crc_cnt_q[5:3], addr_q, func_q, w0_q, w1_q, crc);
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d   = StCrc;
          latch     = 1'b1;
          crc_clr   = 1'b1;
          crc_cnt_d = '0;
          retry_d   = '0;
        end
      end
      StCrc: begin
        // A new byte every 8 clocks; the engine shifts its remaining bits in between.
        crc_load = (crc_cnt_q[2:0] == 3'd0);
        if (crc_cnt_q == CrcLast) begin
          state_d   = StGap;
          gap_cnt_d = '0;
        end else begin
          crc_cnt_d = crc_cnt_q + 6'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d    = StSend;
          idx_d      = '0;
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte(3'd0, addr_q, func_q, w0_q, w1_q, crc);
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StSend: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done) begin
          if (idx_q == LastIdx) begin
            state_d   = StWaitRsp;
            rsp_cnt_d = '0;
          end else begin
            state_d    = StSend;
            idx_d      = idx_q + 3'd1;
            tx_start_d = 1'b1;
            tx_data_d  = frame_byte(idx_q + 3'd1, addr_q, func_q, w0_q, w1_q, crc);
          end
        end
      end
      StWaitRsp: begin
        // A response arriving on the expiry cycle still counts.
        if (rsp_done) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (rsp_cnt_q == RspLast) begin
          if (retry_q < MaxRetry) begin
            retry_d   = retry_q + 3'd1;
            state_d   = StGap;
            gap_cnt_d = '0;
          end else begin
            state_d   = StIdle;
            timeout_d = 1'b1;
          end
        end else begin
          rsp_cnt_d = rsp_cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, request latch and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rsp_cnt_q  <= '0;
      idx_q      <= '0;
      retry_q    <= '0;
      addr_q     <= '0;
      func_q     <= '0;
      w0_q       <= '0;
      w1_q       <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      crc_cnt_q  <= crc_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      idx_q      <= idx_d;
      retry_q    <= retry_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      if (latch) begin
        addr_q <= req_dev_addr;
        func_q <= req_func;
        w0_q   <= req_word0;
        w1_q   <= req_word1;
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign frame_crc = crc;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_modbus_rtu_master_sequencer.sv
// Scoreboard bench for the Modbus RTU master sequencer: stimulus pushes the expected
// byte stream and completion events; a negedge monitor pops and compares them.
module tb_modbus_rtu_master_sequencer;

  localparam int unsigned Gap  = 60;
  localparam int unsigned Rsp  = 200;
  localparam int unsigned Retr = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_dev_addr = '0;
  logic [7:0]  req_func = '0;
  logic [15:0] req_word0 = '0;
  logic [15:0] req_word1 = '0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        rsp_done = 1'b0;
  logic        busy;
  logic [15:0] frame_crc;
  logic        done;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;

  logic [7:0] exp_q[$];
  logic       exp_evt[$];  // 0 = done, 1 = timeout

  modbus_rtu_master_sequencer #(
    .GAP_CLKS    (Gap),
    .RSP_TIMEOUT (Rsp),
    .MAX_RETRY   (Retr)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dev_addr (req_dev_addr),
    .req_func     (req_func),
    .req_word0    (req_word0),
    .req_word1    (req_word1),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done      (tx_done),
    .rsp_done     (rsp_done),
    .busy         (busy),
    .frame_crc    (frame_crc),
    .done         (done),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: every tx_start must match the next expected byte, every done/timeout
  // pulse the next expected event.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_unexpected: got byte %0h, expected no tx_start", tx_data);
        end else begin
          check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (done || timeout) begin
        if (exp_evt.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL evt_unexpected: got done=%0b timeout=%0b, expected none", done, timeout);
        end else begin
          logic e;
          e = exp_evt.pop_front();
          check("evt_done", {31'h0, done}, {31'h0, ~e});
          check("evt_timeout", {31'h0, timeout}, {31'h0, e});
        end
      end
    end
  end

  // Reference CRC16/Modbus, byte-at-a-time over the six request bytes.
  function automatic logic [15:0] crc_model(input logic [47:0] msg);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 5; i >= 0; i--) begin
      c ^= {8'h00, msg[i*8 +: 8]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] a, input logic [7:0] f, input logic [15:0] w0,
                            input logic [15:0] w1, input logic [15:0] c, input int n);
    logic [7:0] b [8];
    b = '{a, f, w0[15:8], w0[7:0], w1[15:8], w1[7:0], c[7:0], c[15:8]};
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] f, input logic [15:0] w0,
                          input logic [15:0] w1);
    @(posedge clk);
    #1;
    check("req_ready_before", {31'h0, req_ready}, 32'h1);
    req_valid    = 1'b1;
    req_dev_addr = a;
    req_func     = f;
    req_word0    = w0;
    req_word1    = w1;
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    req_valid  = 1'b0;
  endtask

  task automatic wait_tx_start(output bit found);
    found = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (tx_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL tx_start_wait: got no tx_start in 2000 clks, expected one");
    end
  endtask

  // Acts as the byte UART: answer each tx_start with tx_done 4 clocks later.
  task automatic serve_bytes(input int n);
    bit found;
    for (int i = 0; i < n; i++) begin
      wait_tx_start(found);
      if (!found) return;
      repeat (3) @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
    end
  endtask

  task automatic pulse_rsp();
    #1 rsp_done = 1'b1;
    @(posedge clk);
    #1 rsp_done = 1'b0;
  endtask

  task automatic wait_evt(input int limit);
    bit found;
    found = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (done || timeout) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL evt_wait: got no done/timeout in %0d clks, expected one", limit);
    end
  endtask

  initial begin
    bit found;
    logic [15:0] c;

    // Reset values.
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_frame_crc", {16'h0, frame_crc}, 32'hFFFF);
    check("rst_done_timeout", {30'h0, done, timeout}, 32'h0);
    rst = 1'b0;

    // 1: read holding register, hand-known CRC D5 CA.
    push_frame(8'h01, 8'h03, 16'h0001, 16'h0001, 16'hCAD5, 8);
    exp_evt.push_back(1'b0);
    send_req(8'h01, 8'h03, 16'h0001, 16'h0001);
    serve_bytes(8);
    check("t1_frame_crc", {16'h0, frame_crc}, 32'hCAD5);
    repeat (10) @(posedge clk);
    pulse_rsp();
    wait_evt(50);

    // 2: address F0 gives CRC bytes C0 EB; gap and CRC time before first byte.
    push_frame(8'hF0, 8'h03, 16'h0001, 16'h0001, 16'hEBC0, 8);
    exp_evt.push_back(1'b0);
    send_req(8'hF0, 8'h03, 16'h0001, 16'h0001);
    wait_tx_start(found);
    check("t2_first_byte_latency", {31'h0, (cyc - accept_cyc) >= int'(Gap + 48)}, 32'h1);
    check("t2_frame_crc", {16'h0, frame_crc}, 32'hEBC0);
    repeat (3) @(posedge clk);
    #1 tx_done = 1'b1;
    @(posedge clk);
    #1 tx_done = 1'b0;
    serve_bytes(7);
    repeat (5) @(posedge clk);
    pulse_rsp();
    wait_evt(50);

    // 3: write single register, response 100 clks later, busy drops after done.
    c = crc_model({8'h01, 8'h06, 16'h0001, 16'h0007});
    push_frame(8'h01, 8'h06, 16'h0001, 16'h0007, c, 8);
    exp_evt.push_back(1'b0);
    send_req(8'h01, 8'h06, 16'h0001, 16'h0007);
    serve_bytes(8);
    check("t3_frame_crc", {16'h0, frame_crc}, {16'h0, c});
    repeat (100) @(posedge clk);
    pulse_rsp();
    wait_evt(50);
    check("t3_done_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("t3_busy_after", {31'h0, busy}, 32'h0);
    check("t3_done_one_cycle", {31'h0, done}, 32'h0);

    // 4: no response: three transmissions of the same frame, then timeout.
    c = crc_model({8'h11, 8'h04, 16'h0100, 16'h0002});
    for (int i = 0; i <= int'(Retr); i++) push_frame(8'h11, 8'h04, 16'h0100, 16'h0002, c, 8);
    exp_evt.push_back(1'b1);
    send_req(8'h11, 8'h04, 16'h0100, 16'h0002);
    serve_bytes(8 * (Retr + 1));
    wait_evt(Rsp + 50);
    check("t4_busy_at_timeout", {31'h0, busy}, 32'h0);
    check("t4_crc_reused", {16'h0, frame_crc}, {16'h0, c});
    check("t4_all_sent", exp_q.size(), 32'h0);

    // 5: reset during byte 4 aborts at once; next request runs cleanly.
    c = crc_model({8'h22, 8'h03, 16'h0010, 16'h0004});
    push_frame(8'h22, 8'h03, 16'h0010, 16'h0004, c, 5);
    send_req(8'h22, 8'h03, 16'h0010, 16'h0004);
    serve_bytes(4);
    wait_tx_start(found);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("t5_rst_busy", {31'h0, busy}, 32'h0);
    check("t5_rst_req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    check("t5_drained", exp_q.size(), 32'h0);
    push_frame(8'h01, 8'h03, 16'h0001, 16'h0001, 16'hCAD5, 8);
    exp_evt.push_back(1'b0);
    send_req(8'h01, 8'h03, 16'h0001, 16'h0001);
    serve_bytes(8);
    repeat (3) @(posedge clk);
    pulse_rsp();
    wait_evt(50);

    // 6: rsp_done on the expiry cycle wins: done, no timeout, no resend.
    c = crc_model({8'h05, 8'h03, 16'h0002, 16'h000A});
    push_frame(8'h05, 8'h03, 16'h0002, 16'h000A, c, 8);
    exp_evt.push_back(1'b0);
    send_req(8'h05, 8'h03, 16'h0002, 16'h000A);
    serve_bytes(8);
    repeat (Rsp - 1) @(posedge clk);
    pulse_rsp();
    wait_evt(20);
    repeat (Gap + Rsp + 100) @(posedge clk);
    #1;
    check("t6_idle", {31'h0, busy}, 32'h0);
    check("end_bytes_left", exp_q.size(), 32'h0);
    check("end_events_left", exp_evt.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
